// File: rtl/gtp_rx_deframer.sv
// Recovers 5-byte comma-delimited frames from a GTP receive stream and
// serialises each accepted frame byte-by-byte into a downstream FIFO.
module gtp_rx_deframer (
  input  logic        gt_rxusrclk_in,
  input  logic        reset_n_in,
  input  logic [15:0] gt_rxdata_in,
  input  logic [1:0]  gt_rxcharisk_in,
  output logic [39:0] frame_data_out,
  output logic        frame_valid_out,
  output logic        FifoWrEnb,
  output logic [7:0]  FifoWrData,
  input  logic        FifoFull,
  output logic [7:0]  err_count_out,
  output logic [7:0]  ovf_count_out,
  output logic [23:0] frame_count_out
);

  typedef enum logic [2:0] {HUNT, B1, B2, B3, B4} state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [39:0] frame_q, frame_d;
  logic        valid_q, valid_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  ovf_q, ovf_d;
  logic [23:0] fcnt_q, fcnt_d;
  logic [39:0] wr_frame_q, wr_frame_d;
  logic [2:0]  wr_cnt_q, wr_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        is_comma, is_data, frame_done, frame_err, emit, can_load;
  logic [7:0]  byte_in;

  assign is_comma = (gt_rxcharisk_in == 2'b01) && (gt_rxdata_in[7:0] == 8'hBC);
  assign is_data  = (gt_rxcharisk_in == 2'b00) && (gt_rxdata_in[7:0] == 8'h00);
  assign byte_in  = gt_rxdata_in[15:8];

  // Deframer: bytes accumulate in a shift register; a comma anywhere restarts it.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      HUNT: begin
        if (is_comma) begin
          shift_d = {shift_q[23:0], byte_in};
          state_d = B1;
        end
      end
      B1, B2, B3, B4: begin
        if (is_data) begin
          shift_d = {shift_q[23:0], byte_in};
          case (state_q)
            B1:      state_d = B2;
            B2:      state_d = B3;
            B3:      state_d = B4;
            default: begin
              state_d    = HUNT;
              frame_done = 1'b1;
            end
          endcase
        end else if (is_comma) begin
          frame_err = 1'b1;
          shift_d   = {shift_q[23:0], byte_in};
          state_d   = B1;
        end else begin
          frame_err = 1'b1;
          state_d   = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Frame output, counters and byte writer.
  always_comb begin
    frame_d    = frame_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    ovf_d      = ovf_q;
    fcnt_d     = fcnt_q;
    wr_frame_d = wr_frame_q;
    wr_cnt_d   = wr_cnt_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    emit       = (wr_cnt_q != 3'd0) && !FifoFull;
    can_load   = (wr_cnt_q == 3'd0) || ((wr_cnt_q == 3'd1) && !FifoFull);

    if (frame_err && (err_q != 8'hFF)) err_d = err_q + 8'd1;

    if (emit) begin
      wr_en_d    = 1'b1;
      wr_data_d  = wr_frame_q[39:32];
      wr_frame_d = {wr_frame_q[31:0], 8'h00};
      wr_cnt_d   = wr_cnt_q - 3'd1;
    end

    if (frame_done) begin
      frame_d = {shift_q, byte_in};
      valid_d = 1'b1;
      fcnt_d  = fcnt_q + 24'd1;
      // A load overrides the emit bookkeeping above; when the last byte of the
      // previous frame leaves on this same edge, the writer is already free.
      if (can_load) begin
        wr_frame_d = {shift_q, byte_in};
        wr_cnt_d   = 3'd5;
      end else if (ovf_q != 8'hFF) begin
        ovf_d = ovf_q + 8'd1;
      end
    end
  end

  always_ff @(posedge gt_rxusrclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= HUNT;
      shift_q    <= '0;
      frame_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= '0;
      ovf_q      <= '0;
      fcnt_q     <= '0;
      wr_frame_q <= '0;
      wr_cnt_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      frame_q    <= frame_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      fcnt_q     <= fcnt_d;
      wr_frame_q <= wr_frame_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign frame_data_out  = frame_q;
  assign frame_valid_out = valid_q;
  assign FifoWrEnb       = wr_en_q;
  assign FifoWrData      = wr_data_q;
  assign err_count_out   = err_q;
  assign ovf_count_out   = ovf_q;
  assign frame_count_out = fcnt_q;

endmodule

// File: tb/tb_gtp_rx_deframer.sv
// Scoreboard bench for gtp_rx_deframer: directed scenarios plus random traffic
// against a word-level reference model.
module tb_gtp_rx_deframer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rxdata;
  logic [1:0]  rxk;
  logic        full;
  logic [39:0] frame_data;
  logic        frame_valid;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  err_cnt, ovf_cnt;
  logic [23:0] frm_cnt;

  gtp_rx_deframer dut (
    .gt_rxusrclk_in (clk),
    .reset_n_in     (rst_n),
    .gt_rxdata_in   (rxdata),
    .gt_rxcharisk_in(rxk),
    .frame_data_out (frame_data),
    .frame_valid_out(frame_valid),
    .FifoWrEnb      (wr_en),
    .FifoWrData     (wr_data),
    .FifoFull       (full),
    .err_count_out  (err_cnt),
    .ovf_count_out  (ovf_cnt),
    .frame_count_out(frm_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [39:0] exp_frames[$];
  logic [7:0]  exp_bytes[$];

  bit          m_hunting = 1'b1;
  logic [7:0]  m_col[$];
  int          m_pending = 0;
  logic [7:0]  m_err = '0;
  logic [7:0]  m_ovf = '0;
  logic [23:0] m_fcnt = '0;
  int          run = 0;
  int          max_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one call per receive word, i.e. per rising edge.
  task automatic model_step(input logic [15:0] d, input logic [1:0] kk, input logic f);
    bit          comma, data, done;
    logic [39:0] fr;
    int          pre;
    comma = (kk == 2'b01) && (d[7:0] == 8'hBC);
    data  = (kk == 2'b00) && (d[7:0] == 8'h00);
    done  = 1'b0;
    fr    = '0;
    if (comma) begin
      if (!m_hunting && m_err != 8'hFF) m_err++;
      m_col.delete();
      m_col.push_back(d[15:8]);
      m_hunting = 1'b0;
    end else if (!m_hunting) begin
      if (data) begin
        m_col.push_back(d[15:8]);
        if (m_col.size() == 5) begin
          done = 1'b1;
          fr = {m_col[0], m_col[1], m_col[2], m_col[3], m_col[4]};
          m_col.delete();
          m_hunting = 1'b1;
        end
      end else begin
        if (m_err != 8'hFF) m_err++;
        m_col.delete();
        m_hunting = 1'b1;
      end
    end
    pre = m_pending;
    if (pre > 0 && !f) m_pending = pre - 1;
    if (done) begin
      exp_frames.push_back(fr);
      m_fcnt++;
      if (pre == 0 || (pre == 1 && !f)) begin
        for (int i = 4; i >= 0; i--) exp_bytes.push_back(fr[i*8 +: 8]);
        m_pending = 5;
      end else if (m_ovf != 8'hFF) begin
        m_ovf++;
      end
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] kk, input logic f);
    @(negedge clk);
    rxdata = d;
    rxk    = kk;
    full   = f;
    model_step(d, kk, f);
  endtask

  task automatic send_frame(input logic [39:0] fr);
    drive({fr[39:32], 8'hBC}, 2'b01, 1'b0);
    for (int i = 3; i >= 0; i--) drive({fr[i*8 +: 8], 8'h00}, 2'b00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0000, 2'b00, 1'b0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_err"}, err_cnt, m_err);
    check({tag, "_ovf"}, ovf_cnt, m_ovf);
    check({tag, "_frames"}, frm_cnt, m_fcnt);
    check({tag, "_missing_frames"}, exp_frames.size(), 0);
    check({tag, "_missing_bytes"}, exp_bytes.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_frame_data"}, frame_data, 0);
    check({tag, "_frame_valid"}, frame_valid, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_ovf"}, ovf_cnt, 0);
    check({tag, "_frames"}, frm_cnt, 0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    exp_frames.delete();
    exp_bytes.delete();
    m_col.delete();
    m_hunting = 1'b1;
    m_pending = 0;
    m_err = '0;
    m_ovf = '0;
    m_fcnt = '0;
    rxdata = '0;
    rxk = '0;
    full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (frame_valid) begin
        if (exp_frames.size() == 0) check("unexpected_frame", 1, 0);
        else check("frame_data", frame_data, exp_frames.pop_front());
      end
      if (wr_en) begin
        run++;
        if (exp_bytes.size() == 0) check("unexpected_write", 1, 0);
        else check("fifo_byte", wr_data, exp_bytes.pop_front());
      end else begin
        run = 0;
      end
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  initial begin
    rst_n  = 1'b0;
    rxdata = '0;
    rxk    = '0;
    full   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send_frame(40'h0111223344);
    idle(8);
    check_counts("single");
    check("single_count", frm_cnt, 1);

    max_run = 0;
    for (int i = 0; i < 10; i++) send_frame({8'(i), 32'($urandom)});
    idle(8);
    check_counts("b2b");
    check("b2b_run", max_run, 50);

    do_reset("rst_resync");
    drive(16'h01BC, 2'b01, 1'b0);
    drive(16'hAA00, 2'b00, 1'b0);
    drive(16'h02BC, 2'b01, 1'b0);
    for (int i = 3; i <= 6; i++) drive({8'(i), 8'h00}, 2'b00, 1'b0);
    idle(8);
    check_counts("resync");
    drive(16'h01BC, 2'b01, 1'b0);
    drive(16'hAA00, 2'b00, 1'b0);
    drive(16'h0101, 2'b01, 1'b0);
    idle(4);
    check_counts("badword");

    do_reset("rst_ovf");
    send_frame(40'hA1A2A3A4A5);
    drive(16'hB1BC, 2'b01, 1'b0);
    drive(16'hB200, 2'b00, 1'b0);
    drive(16'hB300, 2'b00, 1'b1);
    drive(16'hB400, 2'b00, 1'b1);
    drive(16'hB500, 2'b00, 1'b1);
    idle(8);
    check_counts("pause_ovf");
    check("ovf_one", ovf_cnt, 1);

    do_reset("rst_pre_b2");
    drive(16'h01BC, 2'b01, 1'b0);
    drive(16'h1100, 2'b00, 1'b0);
    do_reset("rst_b2");
    idle(3);
    send_frame(40'h5566778899);
    idle(3);
    do_reset("rst_write");
    idle(10);
    check_counts("post_reset_quiet");
    send_frame(40'hC0C1C2C3C4);
    idle(8);
    check_counts("post_reset_frame");

    do_reset("rst_random");
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [15:0] w;
      logic [1:0]  kk;
      r = $urandom_range(0, 99);
      w = 16'($urandom);
      if (r < 15) begin
        w[7:0] = 8'hBC; kk = 2'b01;
      end else if (r < 92) begin
        w[7:0] = 8'h00; kk = 2'b00;
      end else begin
        kk = 2'($urandom);
      end
      drive(w, kk, ($urandom_range(0, 3) == 0));
    end
    idle(12);
    check_counts("random");

    do_reset("rst_sat");
    for (int i = 0; i < 300; i++) begin
      drive(16'h01BC, 2'b01, 1'b0);
      drive(16'h0101, 2'b01, 1'b0);
    end
    idle(4);
    check_counts("saturate");
    check("err_sat", err_cnt, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
